// File: rtl/edge_pulse_gen_if.sv
// Bundles the channel inputs, shared controls and pulse/flag outputs of edge_pulse_gen.
// The master side drives the levels and controls. The slave side is the pulse generator.
interface edge_pulse_gen_if #(
  parameter int WIDTH = 1
) ();
  logic [WIDTH-1:0] signal_in;
  logic [1:0]       edge_mode;
  logic [WIDTH-1:0] flag_clr;
  logic [WIDTH-1:0] pulse_out;
  logic             any_pulse;
  logic [WIDTH-1:0] event_flags;

  modport master (
    output signal_in,
    output edge_mode,
    output flag_clr,
    input  pulse_out,
    input  any_pulse,
    input  event_flags
  );

  modport slave (
    input  signal_in,
    input  edge_mode,
    input  flag_clr,
    output pulse_out,
    output any_pulse,
    output event_flags
  );
endinterface

// File: rtl/edge_pulse_gen.sv
// Per-channel edge detector that stretches each detected edge into a fixed-length pulse.
// Each channel also keeps a sticky flag. Detection is held off until the synchronizer has refilled after reset.
module edge_pulse_gen #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_LEN   = 1,
  parameter int RETRIGGER   = 0
) (
  input logic            clk,
  input logic            rst,
  edge_pulse_gen_if.slave bus
);

  localparam int            CW       = $clog2(PULSE_LEN + 1);
  localparam logic [CW-1:0] LOAD     = CW'(PULSE_LEN);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [2:0]    ARM_DONE = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] w_det;
  logic [WIDTH-1:0] r_flags;
  logic [WIDTH-1:0] r_pulse;
  logic [WIDTH-1:0] w_pulse_nxt;
  logic [CW-1:0]    r_cnt     [WIDTH];
  logic [CW-1:0]    w_cnt_nxt [WIDTH];
  logic [2:0]       r_arm;
  logic             w_armed;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_s = bus.signal_in;
    end else begin : g_sync
      logic [WIDTH-1:0] r_sync [SYNC_STAGES];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
        end else begin
          r_sync[0] <= bus.signal_in;
          for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
        end
      end

      assign w_s = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  // Arming counter saturates once the synchronizer and previous-sample registers hold real data
  always_ff @(posedge clk) begin
    if (rst) begin
      r_arm <= '0;
      r_p   <= '0;
    end else begin
      if (!w_armed) r_arm <= r_arm + 3'd1;
      r_p <= w_s;
    end
  end

  assign w_armed = (r_arm == ARM_DONE);

  always_comb begin
    w_det = '0;
    if (w_armed) begin
      case (bus.edge_mode)
        2'b00:   w_det = w_s & ~r_p;
        2'b01:   w_det = ~w_s & r_p;
        2'b10:   w_det = w_s ^ r_p;
        default: w_det = '0;
      endcase
    end
  end

  // Next counter value; the pulse register is loaded from it so pulse_out comes straight from a flop
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_nxt[i]   = r_cnt[i];
      w_pulse_nxt[i] = 1'b0;
      if (w_det[i] && ((r_cnt[i] == '0) || (RETRIGGER != 0))) begin
        w_cnt_nxt[i] = LOAD;
      end else if (r_cnt[i] != '0) begin
        w_cnt_nxt[i] = r_cnt[i] - ONE;
      end
      w_pulse_nxt[i] = (w_cnt_nxt[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
      r_pulse <= '0;
      r_flags <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= w_cnt_nxt[i];
      r_pulse <= w_pulse_nxt;
      r_flags <= (r_flags & ~bus.flag_clr) | w_det;
    end
  end

  assign bus.pulse_out   = r_pulse;
  assign bus.any_pulse   = |r_pulse;
  assign bus.event_flags = r_flags;

endmodule

// File: tb/tb_edge_pulse_gen.sv
// Self-checking bench for edge_pulse_gen across several parameter sets.
// Expected outputs are queued with each stimulus cycle and compared one cycle later.
module tb_edge_pulse_gen;

  typedef struct {
    logic       rstIn;
    logic [3:0] sig;
    logic [1:0] mode;
    logic [3:0] clr;
    logic [3:0] expP;
    logic [3:0] expF;
  } vec_t;

  typedef struct {
    int         dut;
    logic [3:0] pulse;
    logic [3:0] flags;
    string      tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checkCount = 0;
  int   passCount  = 0;
  exp_t sbQ[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  edge_pulse_gen_if #(.WIDTH(1)) ifA ();
  edge_pulse_gen_if #(.WIDTH(4)) ifB ();
  edge_pulse_gen_if #(.WIDTH(1)) ifC ();
  edge_pulse_gen_if #(.WIDTH(1)) ifD ();
  edge_pulse_gen_if #(.WIDTH(1)) ifE ();

  edge_pulse_gen #(.WIDTH(1), .SYNC_STAGES(0), .PULSE_LEN(1), .RETRIGGER(0))
    dutA (.clk(clk), .rst(rst), .bus(ifA));
  edge_pulse_gen #(.WIDTH(4), .SYNC_STAGES(2), .PULSE_LEN(3), .RETRIGGER(0))
    dutB (.clk(clk), .rst(rst), .bus(ifB));
  edge_pulse_gen #(.WIDTH(1), .SYNC_STAGES(2), .PULSE_LEN(4), .RETRIGGER(0))
    dutC (.clk(clk), .rst(rst), .bus(ifC));
  edge_pulse_gen #(.WIDTH(1), .SYNC_STAGES(2), .PULSE_LEN(4), .RETRIGGER(1))
    dutD (.clk(clk), .rst(rst), .bus(ifD));
  edge_pulse_gen #(.WIDTH(1), .SYNC_STAGES(1), .PULSE_LEN(8), .RETRIGGER(1))
    dutE (.clk(clk), .rst(rst), .bus(ifE));

  task automatic addRows(input int n, input logic r, input logic [3:0] s, input logic [1:0] m,
                         input logic [3:0] c, input logic [3:0] p, input logic [3:0] f);
    vec_t v;
    v.rstIn = r; v.sig = s; v.mode = m; v.clr = c; v.expP = p; v.expF = f;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  task automatic readDut(input int d, output logic [3:0] p, output logic a, output logic [3:0] f);
    p = 4'b0; a = 1'b0; f = 4'b0;
    case (d)
      0: begin p = {3'b0, ifA.pulse_out}; a = ifA.any_pulse; f = {3'b0, ifA.event_flags}; end
      1: begin p = ifB.pulse_out;          a = ifB.any_pulse; f = ifB.event_flags;          end
      2: begin p = {3'b0, ifC.pulse_out}; a = ifC.any_pulse; f = {3'b0, ifC.event_flags}; end
      3: begin p = {3'b0, ifD.pulse_out}; a = ifD.any_pulse; f = {3'b0, ifD.event_flags}; end
      default: begin p = {3'b0, ifE.pulse_out}; a = ifE.any_pulse; f = {3'b0, ifE.event_flags}; end
    endcase
  endtask

  task automatic cmp(input string tag, input string what, input logic [3:0] act, input logic [3:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s %s: got %b expected %b", tag, what, act, exp);
  endtask

  task automatic checkOutput();
    exp_t e;
    logic [3:0] ap, af;
    logic aa;
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      readDut(e.dut, ap, aa, af);
      cmp(e.tag, "pulse_out", ap, e.pulse);
      cmp(e.tag, "any_pulse", {3'b0, aa}, {3'b0, |e.pulse});
      cmp(e.tag, "event_flags", af, e.flags);
    end
  endtask

  task automatic pushExp(input int d, input logic [3:0] p, input logic [3:0] f, input string tag);
    exp_t e;
    e.dut = d; e.pulse = p; e.flags = f; e.tag = tag;
    sbQ.push_back(e);
  endtask

  task automatic applyStimulus(input int d, input logic [3:0] p, input logic [3:0] f, input string tag);
    pushExp(d, p, f, tag);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    logic [3:0] expP, expPD, expF;

    ifA.signal_in = '0; ifA.edge_mode = 2'b11; ifA.flag_clr = '0;
    ifB.signal_in = '0; ifB.edge_mode = 2'b11; ifB.flag_clr = '0;
    ifC.signal_in = '0; ifC.edge_mode = 2'b11; ifC.flag_clr = '0;
    ifD.signal_in = '0; ifD.edge_mode = 2'b11; ifD.flag_clr = '0;
    ifE.signal_in = '0; ifE.edge_mode = 2'b11; ifE.flag_clr = '0;

    // Four channels: arming, simultaneous rise/fall, flag clear vs detection, mode 11, mode change mid-pulse
    addRows(1, 1'b1, 4'b0100, 2'b10, 4'b0000, 4'b0000, 4'b0000);
    addRows(9, 1'b0, 4'b0100, 2'b10, 4'b0000, 4'b0000, 4'b0000);
    addRows(2, 1'b0, 4'b0001, 2'b10, 4'b0000, 4'b0000, 4'b0000);
    addRows(3, 1'b0, 4'b0001, 2'b10, 4'b0000, 4'b0101, 4'b0101);
    addRows(1, 1'b0, 4'b0001, 2'b10, 4'b0000, 4'b0000, 4'b0101);
    addRows(1, 1'b0, 4'b0001, 2'b00, 4'b0101, 4'b0000, 4'b0000);
    addRows(2, 1'b0, 4'b0011, 2'b00, 4'b0000, 4'b0000, 4'b0000);
    addRows(3, 1'b0, 4'b0011, 2'b00, 4'b0000, 4'b0010, 4'b0010);
    addRows(2, 1'b0, 4'b0001, 2'b01, 4'b0000, 4'b0000, 4'b0010);
    addRows(1, 1'b0, 4'b0001, 2'b01, 4'b0010, 4'b0010, 4'b0010);
    addRows(1, 1'b0, 4'b0001, 2'b01, 4'b0010, 4'b0010, 4'b0000);
    addRows(1, 1'b0, 4'b0001, 2'b01, 4'b0000, 4'b0010, 4'b0000);
    addRows(5, 1'b0, 4'b1110, 2'b11, 4'b0000, 4'b0000, 4'b0000);
    addRows(2, 1'b0, 4'b1111, 2'b00, 4'b0000, 4'b0000, 4'b0000);
    addRows(1, 1'b0, 4'b1111, 2'b00, 4'b0000, 4'b0001, 4'b0001);
    addRows(2, 1'b0, 4'b1111, 2'b11, 4'b0000, 4'b0001, 4'b0001);
    addRows(1, 1'b0, 4'b1111, 2'b11, 4'b0000, 4'b0000, 4'b0001);

    foreach (tbl[n]) begin
      rst = tbl[n].rstIn;
      ifB.signal_in = tbl[n].sig;
      ifB.edge_mode = tbl[n].mode;
      ifB.flag_clr  = tbl[n].clr;
      applyStimulus(1, tbl[n].expP, tbl[n].expF, $sformatf("B.tbl%0d", n));
    end

    // Input high through reset must not pulse; a later 1->0->1 gives one rising pulse
    ifB.edge_mode = 2'b00;
    ifB.flag_clr  = '0;
    for (int c = 0; c <= 21; c++) begin
      rst = (c == 0);
      ifB.signal_in = (c >= 11 && c <= 13) ? 4'b0000 : 4'b1111;
      expP = (c >= 16 && c <= 18) ? 4'b1111 : 4'b0000;
      expF = (c >= 16) ? 4'b1111 : 4'b0000;
      applyStimulus(1, expP, expF, $sformatf("B.steady%0d", c));
    end

    // No synchronizer: pulse right after the sampling edge, falling edge ignored in mode 00
    ifA.edge_mode = 2'b00;
    for (int c = 0; c <= 21; c++) begin
      rst = (c == 0);
      ifA.signal_in = (c >= 10 && c < 20);
      expP = (c == 10) ? 4'b0001 : 4'b0000;
      expF = (c >= 10) ? 4'b0001 : 4'b0000;
      applyStimulus(0, expP, expF, $sformatf("A.e%0d", c));
    end

    // Second edge two cycles after the first: ignored (C) vs pulse extension (D)
    ifC.edge_mode = 2'b10;
    ifD.edge_mode = 2'b10;
    for (int c = 0; c <= 19; c++) begin
      rst = (c == 0);
      ifC.signal_in = (c >= 10 && c < 12);
      ifD.signal_in = (c >= 10 && c < 12);
      ifC.flag_clr  = (c == 13);
      ifD.flag_clr  = (c == 13);
      expP  = (c >= 12 && c <= 15) ? 4'b0001 : 4'b0000;
      expPD = (c >= 12 && c <= 17) ? 4'b0001 : 4'b0000;
      expF  = (c == 12 || c >= 14) ? 4'b0001 : 4'b0000;
      pushExp(2, expP, expF, $sformatf("C.e%0d", c));
      applyStimulus(3, expPD, expF, $sformatf("D.e%0d", c));
    end

    // Reset one cycle into a long pulse kills it with no residue afterwards
    ifE.edge_mode = 2'b00;
    for (int c = 0; c <= 18; c++) begin
      rst = (c == 0 || c == 8);
      ifE.signal_in = (c >= 6);
      expP = (c == 7) ? 4'b0001 : 4'b0000;
      applyStimulus(4, expP, expP, $sformatf("E.e%0d", c));
    end

    rst = 1'b0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
